fetch_queue: RTL and testbench

//  Instruction buffer between the IF stage and the ID stage of the SCC.
//  - Captures each fetched {pc, instruction} pair from IF into a small FIFO.
//  - Presents the oldest entry to ID using a valid/ready handshake.
//  - Back-pressures IF with fetch_stall; IF holds its PC while stall is high.
//  - Discards all buffered entries on a taken branch (flush).

---
 rtl/fetch_queue_pkg.sv | 22 ++
 rtl/fq_storage.sv | 24 ++
 rtl/fetch_queue.sv | 88 ++++++++
 tb/tb_fetch_queue.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the fetch queue and the stages around it.
package fetch_queue_pkg;

  localparam int          SCC_WORD_W  = 32;
  localparam logic [31:0] SCC_NOP     = 32'h0000_0000;
  // PC advance per sequential fetch; the IF stage uses the same step.
  localparam int          SCC_PC_STEP = 4;

  // Occupancy action taken at a clock edge.
  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

  function automatic cnt_op_e cnt_op(input logic push, input logic pop);
    cnt_op = CNT_HOLD;
    if (push && !pop) cnt_op = CNT_INC;
    if (pop && !push) cnt_op = CNT_DEC;
  endfunction

endpackage

// File: rtl/fq_storage.sv
// Register array for the fetch queue: one write port, one asynchronous read port.
module fq_storage #(
  parameter int DEPTH  = 4,
  parameter int WIDTH  = 64,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write the addressed entry; contents are never cleared.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_queue.sv
// IF-to-ID instruction buffer: FIFO of {pc, instruction} pairs with
// first-word fall-through, stall on full, flush on taken branch and a
// sticky overflow flag.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int  DEPTH  = 4,
  parameter int  WORD_W = SCC_WORD_W,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              fetch_valid,
  input  logic [WORD_W-1:0] fetch_pc,
  input  logic [WORD_W-1:0] fetch_instruction,
  output logic              fetch_stall,
  input  logic              id_ready,
  output logic              id_valid,
  output logic [WORD_W-1:0] id_pc,
  output logic [WORD_W-1:0] id_instruction,
  output logic [CNT_W-1:0]  count,
  output logic              overflow_err
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]    r_rd_ptr;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [CNT_W-1:0]    r_count;
  logic                r_overflow;

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic [2*WORD_W-1:0] w_rdata;

  // Full/empty come from the registered count only, so stall has no
  // combinational dependence on id_ready.
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = fetch_valid && !w_full && !flush;
  assign w_pop   = !w_empty && id_ready && !flush;

  fq_storage #(
    .DEPTH (DEPTH),
    .WIDTH (2 * WORD_W)
  ) u_storage (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata ({fetch_pc, fetch_instruction}),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  // Pointer, occupancy and sticky-error state; reset dominates flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      unique case (cnt_op(w_push, w_pop))
        CNT_INC: r_count <= r_count + CNT_W'(1);
        CNT_DEC: r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (fetch_valid && w_full) r_overflow <= 1'b1;
    end
  end

  assign fetch_stall    = w_full;
  assign id_valid       = !w_empty;
  assign id_pc          = w_empty ? WORD_W'(SCC_NOP) : w_rdata[2*WORD_W-1:WORD_W];
  assign id_instruction = w_empty ? WORD_W'(SCC_NOP) : w_rdata[WORD_W-1:0];
  assign count          = r_count;
  assign overflow_err   = r_overflow;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios followed by random traffic, all
// checked against a queue-based reference model of the buffer.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int W     = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          fetch_valid = 1'b0;
  logic [W-1:0]  fetch_pc = '0;
  logic [W-1:0]  fetch_instruction = '0;
  logic          fetch_stall;
  logic          id_ready = 1'b0;
  logic          id_valid;
  logic [W-1:0]  id_pc;
  logic [W-1:0]  id_instruction;
  logic [2:0]    count;
  logic          overflow_err;

  fetch_queue #(.DEPTH(DEPTH), .WORD_W(W)) dut (
    .clk               (clk),
    .reset             (reset),
    .flush             (flush),
    .fetch_valid       (fetch_valid),
    .fetch_pc          (fetch_pc),
    .fetch_instruction (fetch_instruction),
    .fetch_stall       (fetch_stall),
    .id_ready          (id_ready),
    .id_valid          (id_valid),
    .id_pc             (id_pc),
    .id_instruction    (id_instruction),
    .count             (count),
    .overflow_err      (overflow_err)
  );

  always #5 clk = ~clk;

  // Reference model: the queue contents in order, plus the sticky flag.
  logic [2*W-1:0] mq[$];
  bit             m_ovf;
  bit             chk_en;
  int             n_cmp;
  int             n_err;
  int             max_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output with the model state.
  task automatic check_all(input string tag);
    logic [W-1:0] e_pc, e_ins;
    e_pc  = (mq.size() != 0) ? mq[0][2*W-1:W] : '0;
    e_ins = (mq.size() != 0) ? mq[0][W-1:0]   : '0;
    check({tag, ".count"}, 64'(count),          64'(mq.size()));
    check({tag, ".valid"}, 64'(id_valid),       64'(mq.size() != 0));
    check({tag, ".pc"},    64'(id_pc),          64'(e_pc));
    check({tag, ".instr"}, 64'(id_instruction), 64'(e_ins));
    check({tag, ".stall"}, 64'(fetch_stall),    64'(mq.size() == DEPTH));
    check({tag, ".ovf"},   64'(overflow_err),   64'(m_ovf));
  endtask

  // One clock: drive inputs, check pre-edge outputs, advance the model.
  task automatic cycle(input string tag, input bit rst, input bit fl, input bit fv,
                       input logic [W-1:0] pc, input logic [W-1:0] ins, input bit rdy);
    bit full, pop, push;
    reset = rst; flush = fl; fetch_valid = fv;
    fetch_pc = pc; fetch_instruction = ins; id_ready = rdy;
    #1;
    if (chk_en) check_all(tag);
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
    end else if (fl) begin
      mq.delete();
    end else begin
      full = (mq.size() == DEPTH);
      pop  = (mq.size() != 0) && rdy;
      push = fv && !full;
      if (fv && full) m_ovf = 1'b1;
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back({pc, ins});
    end
    if (mq.size() > max_cnt) max_cnt = mq.size();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] pc;
    n_cmp = 0; n_err = 0; chk_en = 1'b0; m_ovf = 1'b0; max_cnt = 0;
    @(posedge clk); #1;

    // Reset held two clocks with fetch_valid high.
    cycle("rst0", 1, 0, 1, 32'h100, 32'hDEAD, 0);
    chk_en = 1'b1;
    cycle("rst1", 1, 0, 1, 32'h104, 32'hBEEF, 0);
    check_all("reset");

    // Fill with id_ready low, then drain.
    for (int i = 0; i < 4; i++)
      cycle("fill", 0, 0, 1, 32'(i * SCC_PC_STEP), 32'hA0 + 32'(i), 0);
    check("fill.count", 64'(count), 64'd4);
    check("fill.stall", 64'(fetch_stall), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check("drain.pc", 64'(id_pc), 64'(i * SCC_PC_STEP));
      cycle("drain", 0, 0, 0, '0, '0, 1);
    end
    check("drain.valid", 64'(id_valid), 64'd0);

    // Streaming from empty: occupancy settles at one.
    for (int i = 0; i < 8; i++)
      cycle("stream", 0, 0, 1, 32'h200 + 32'(i * SCC_PC_STEP), 32'hB0 + 32'(i), 1);
    check("stream.count", 64'(count), 64'd1);
    cycle("stream_end", 0, 0, 0, '0, '0, 1);

    // Wrap-around: pushes run two ahead of pops.
    max_cnt = 0;
    pc = '0;
    for (int i = 0; i < 12; i++) begin
      cycle("wrap", 0, 0, (i < 10), pc, 32'hC0 + 32'(i), (i >= 2));
      if (i < 10) pc = pc + 32'(SCC_PC_STEP);
    end
    check("wrap.maxcnt", 64'(max_cnt), 64'd2);

    // Flush with three entries queued; the flush-cycle push must vanish.
    for (int i = 0; i < 3; i++)
      cycle("pref", 0, 0, 1, 32'h300 + 32'(i * SCC_PC_STEP), 32'hD0 + 32'(i), 0);
    cycle("flush", 0, 1, 1, 32'hBAD0, 32'hBAD1, 1);
    check("flush.valid", 64'(id_valid), 64'd0);
    cycle("postflush", 0, 0, 0, '0, '0, 1);

    // Overflow: push attempts while full.
    for (int i = 0; i < 4; i++)
      cycle("ofill", 0, 0, 1, 32'h400 + 32'(i * SCC_PC_STEP), 32'hE0 + 32'(i), 0);
    cycle("ovf_hold", 0, 0, 1, 32'h4F0, 32'hEF, 0);
    check("ovf.count", 64'(count), 64'd4);
    cycle("ovf_pop", 0, 0, 1, 32'h4F4, 32'hEE, 1);
    check("ovf.flag", 64'(overflow_err), 64'd1);
    for (int i = 0; i < 4; i++) cycle("odrain", 0, 0, 0, '0, '0, 1);
    check("ovf.sticky", 64'(overflow_err), 64'd1);
    cycle("ovf_rst", 1, 0, 0, '0, '0, 0);
    check("ovf.clear", 64'(overflow_err), 64'd0);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++)
      cycle("rand", ($urandom_range(63) == 0), ($urandom_range(15) == 0),
            ($urandom_range(3) != 0), $urandom, $urandom, ($urandom_range(2) != 0));
    check_all("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
